// File: rtl/wb_mem_adapter_if.sv
// wb_mem_adapter_if
// Classic Wishbone bus bundle between the memory adapter (master) and a
// memory/slave. Handshake: the master holds cyc_o/stb_o high with stable
// we_o/sel_o/adr_o/dat_o until the slave answers with ack_i or err_i for one
// cycle. The master then drops cyc_o/stb_o on the same edge it samples the answer.
//   cyc_o, stb_o, we_o : master -> slave cycle, strobe, write enable
//   sel_o[3:0]         : master -> slave byte enables
//   adr_o[31:0]        : master -> slave byte address
//   dat_o[31:0]        : master -> slave write data
//   dat_i[31:0]        : slave -> master read data
//   ack_i, err_i       : slave -> master termination
interface wb_mem_adapter_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;
  logic        err_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, sel_o, adr_o, dat_o,
    output dat_i, ack_i, err_i
  );
endinterface

// File: rtl/wb_mem_adapter.sv
// wb_mem_adapter
// Turns the request unit's level-style memory request into one classic
// Wishbone transaction. The request is latched on acceptance and the bus is
// driven only from those registers. Each transaction is bounded by an ack
// timeout.
// Ports:
//   clk, nRst            : clock, synchronous active-low reset
//   read_to_mem          : read request (level)
//   write_to_mem         : write request (level, wins over read)
//   sel_to_mem[3:0]      : byte enables
//   adr_to_mem[31:0]     : byte address
//   data_to_mem[31:0]    : write data
//   mem_busy             : request pending or in flight
//   data_from_mem[31:0]  : read data, valid in the DONE cycle, held afterwards
//   bus_error            : one-cycle pulse in DONE on err_i or timeout
//   wb                   : Wishbone master side
//   dbg_state[1:0]       : FSM state (0 IDLE, 1 BUS, 2 DONE)
module wb_mem_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                    clk,
  input  logic                    nRst,
  input  logic                    read_to_mem,
  input  logic                    write_to_mem,
  input  logic [3:0]              sel_to_mem,
  input  logic [31:0]             adr_to_mem,
  input  logic [31:0]             data_to_mem,
  output logic                    mem_busy,
  output logic [31:0]             data_from_mem,
  output logic                    bus_error,
  wb_mem_adapter_if.master        wb,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Exit happens at count TIMEOUT_CYCLES-1, so the 16-bit counter never wraps.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] cnt;
  logic        req;
  logic        timeout;
  logic        end_ok;
  logic        end_err;

  assign req       = read_to_mem | write_to_mem;
  assign timeout   = (cnt == TO_LAST);
  // Termination priority: err_i, then ack_i, then timeout.
  assign end_ok    = wb.ack_i & ~wb.err_i;
  assign end_err   = wb.err_i | (~wb.ack_i & timeout);
  assign dbg_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (!nRst) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = BUS;
      BUS:     if (end_ok || end_err) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic: during reset the FSM is treated as sitting in IDLE.
  always_comb begin
    mem_busy = 1'b0;
    if (!nRst) begin
      mem_busy = req;
    end else begin
      case (state)
        IDLE:    mem_busy = req;
        BUS:     mem_busy = 1'b1;
        default: mem_busy = 1'b0;
      endcase
    end
  end

  // Request latch, bus drive, timeout counter and response capture.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      wb.cyc_o      <= 1'b0;
      wb.stb_o      <= 1'b0;
      wb.we_o       <= 1'b0;
      wb.sel_o      <= 4'h0;
      wb.adr_o      <= 32'h0;
      wb.dat_o      <= 32'h0;
      data_from_mem <= 32'h0;
      bus_error     <= 1'b0;
      cnt           <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          bus_error <= 1'b0;
          if (req) begin
            wb.sel_o <= sel_to_mem;
            wb.adr_o <= adr_to_mem;
            wb.dat_o <= data_to_mem;
            wb.we_o  <= write_to_mem;
            wb.cyc_o <= 1'b1;
            wb.stb_o <= 1'b1;
            cnt      <= 16'h0;
          end
        end
        BUS: begin
          cnt <= cnt + 16'd1;
          if (end_ok || end_err) begin
            wb.cyc_o  <= 1'b0;
            wb.stb_o  <= 1'b0;
            bus_error <= end_err;
            // Writes return zero; reads return bus data or the error pattern.
            if (wb.we_o)      data_from_mem <= 32'h0;
            else if (end_err) data_from_mem <= ERR_DATA;
            else              data_from_mem <= wb.dat_i;
          end
        end
        default: begin
          // DONE: bus_error was high for exactly this cycle.
          bus_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_adapter.sv
module tb_wb_mem_adapter;

  localparam int unsigned TO = 4;
  localparam logic [31:0] ERR_PAT = 32'hDEAD_BEEF;
  localparam logic [1:0]  ST_IDLE = 2'd0;
  localparam logic [1:0]  ST_BUS  = 2'd1;
  localparam logic [1:0]  ST_DONE = 2'd2;

  // response modes for the slave side
  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  logic        clk;
  logic        nRst;
  logic        read_to_mem;
  logic        write_to_mem;
  logic [3:0]  sel_to_mem;
  logic [31:0] adr_to_mem;
  logic [31:0] data_to_mem;
  logic        mem_busy;
  logic [31:0] data_from_mem;
  logic        bus_error;
  logic [1:0]  dbg_state;

  wb_mem_adapter_if wb();

  wb_mem_adapter #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR_PAT)) dut (
    .clk           (clk),
    .nRst          (nRst),
    .read_to_mem   (read_to_mem),
    .write_to_mem  (write_to_mem),
    .sel_to_mem    (sel_to_mem),
    .adr_to_mem    (adr_to_mem),
    .data_to_mem   (data_to_mem),
    .mem_busy      (mem_busy),
    .data_from_mem (data_from_mem),
    .bus_error     (bus_error),
    .wb            (wb),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: {bus_error, data_from_mem} expected at each DONE
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (nRst && dbg_state == ST_DONE) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got DONE with data 0x%08h, expected no transaction", data_from_mem);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("done_data", data_from_mem, e[31:0]);
        check("done_err", {31'h0, bus_error}, {31'h0, e[32]});
      end
    end
  end

  // pattern recorder for back-to-back sequencing
  logic       rec = 1'b0;
  int         rec_n = 0;
  logic [5:0] busy_pat = 6'h0;
  logic [5:0] cyc_pat  = 6'h0;
  always @(negedge clk) begin
    if (rec && rec_n < 6) begin
      busy_pat <= {busy_pat[4:0], mem_busy};
      cyc_pat  <= {cyc_pat[4:0], wb.cyc_o};
      rec_n    <= rec_n + 1;
    end
  end

  // ---------------- driver ----------------
  // Issues one request, answers it in BUS cycle resp_n (1-based) with mode,
  // and checks bus-side copies, busy/cyc cycle counts. Returns at the DONE
  // negedge.
  task automatic run_txn(
    input logic rd, input logic wr, input logic [3:0] sel,
    input logic [31:0] adr, input logic [31:0] data,
    input int mode, input int resp_n, input logic [31:0] rdata,
    input logic alt_adr,
    input int exp_busy, input int exp_cyc,
    input logic [31:0] exp_data, input logic exp_err);
    int busy_cnt;
    int cyc_cnt;
    int n;
    exp_q.push_back({exp_err, exp_data});
    @(posedge clk); #1;
    read_to_mem  = rd;
    write_to_mem = wr;
    sel_to_mem   = sel;
    adr_to_mem   = adr;
    data_to_mem  = data;
    @(negedge clk);
    check("req_busy", {31'h0, mem_busy}, 32'h1);
    check("req_cyc", {31'h0, wb.cyc_o}, 32'h0);
    busy_cnt = 1;
    cyc_cnt  = 0;
    @(posedge clk); #1;
    read_to_mem  = 1'b0;
    write_to_mem = 1'b0;
    if (alt_adr) begin
      adr_to_mem  = 32'h0000_0099;
      data_to_mem = 32'h1111_2222;
      sel_to_mem  = 4'hC;
    end
    n = 1;
    while (dbg_state == ST_BUS && n <= 64) begin
      @(negedge clk);
      if (mem_busy)  busy_cnt++;
      if (wb.cyc_o)  cyc_cnt++;
      if (n == 1 || alt_adr) begin
        check("adr_o", wb.adr_o, adr);
        check("we_o", {31'h0, wb.we_o}, {31'h0, wr});
        check("sel_o", {28'h0, wb.sel_o}, {28'h0, sel});
        check("stb_o", {31'h0, wb.stb_o}, 32'h1);
        if (wr) check("dat_o", wb.dat_o, data);
      end
      if (n == resp_n) begin
        wb.dat_i = rdata;
        wb.ack_i = (mode == M_ACK || mode == M_BOTH);
        wb.err_i = (mode == M_ERR || mode == M_BOTH);
      end
      @(posedge clk); #1;
      wb.ack_i = 1'b0;
      wb.err_i = 1'b0;
      wb.dat_i = 32'h0;
      n++;
    end
    if (n > 64) begin
      checks++;
      errors++;
      $display("FAIL bus_bound: still in BUS after %0d cycles, expected exit", n - 1);
    end
    @(negedge clk);
    check("done_busy", {31'h0, mem_busy}, 32'h0);
    check("done_cyc", {31'h0, wb.cyc_o}, 32'h0);
    check("busy_cycles", busy_cnt, exp_busy);
    check("cyc_cycles", cyc_cnt, exp_cyc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nRst = 1'b0;
    read_to_mem  = 1'b0;
    write_to_mem = 1'b0;
    sel_to_mem   = 4'h0;
    adr_to_mem   = 32'h0;
    data_to_mem  = 32'h0;
    wb.dat_i = 32'h0;
    wb.ack_i = 1'b0;
    wb.err_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 nRst = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    check("rst_cyc", {31'h0, wb.cyc_o}, 32'h0);
    check("rst_stb", {31'h0, wb.stb_o}, 32'h0);
    check("rst_we", {31'h0, wb.we_o}, 32'h0);
    check("rst_sel", {28'h0, wb.sel_o}, 32'h0);
    check("rst_adr", wb.adr_o, 32'h0);
    check("rst_dat", wb.dat_o, 32'h0);
    check("rst_rdata", data_from_mem, 32'h0);
    check("rst_berr", {31'h0, bus_error}, 32'h0);
    check("rst_busy", {31'h0, mem_busy}, 32'h0);

    // read, ack in first BUS cycle
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, M_ACK, 1, 32'h1234_5678, 1'b0,
            2, 1, 32'h1234_5678, 1'b0);

    // write, ack in third BUS cycle, upstream changes during BUS
    run_txn(1'b0, 1'b1, 4'b0011, 32'h0000_0080, 32'hCAFE_F00D, M_ACK, 3, 32'h5555_5555, 1'b1,
            4, 3, 32'h0, 1'b0);

    // read, no response -> timeout after TO BUS cycles
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, M_NONE, 0, 32'h0, 1'b0,
            TO + 1, TO, ERR_PAT, 1'b1);
    @(negedge clk);
    check("berr_pulse_end", {31'h0, bus_error}, 32'h0);
    check("idle_after_done", {30'h0, dbg_state}, {30'h0, ST_IDLE});

    // ack and err together on a read -> error path
    run_txn(1'b1, 1'b0, 4'h1, 32'h0000_0300, 32'h0, M_BOTH, 1, 32'h7777_7777, 1'b0,
            2, 1, ERR_PAT, 1'b1);

    // reset mid-BUS: read to 0x100, never acked
    @(posedge clk); #1;
    read_to_mem = 1'b1;
    adr_to_mem  = 32'h0000_0100;
    sel_to_mem  = 4'hF;
    @(posedge clk); #1;
    read_to_mem = 1'b0;
    @(negedge clk);
    check("midbus_state", {30'h0, dbg_state}, {30'h0, ST_BUS});
    @(posedge clk); #1;
    nRst = 1'b0;
    @(negedge clk);
    check("in_rst_busy", {31'h0, mem_busy}, 32'h0);
    @(posedge clk); #1;
    nRst = 1'b1;
    @(negedge clk);
    check("midrst_cyc", {31'h0, wb.cyc_o}, 32'h0);
    check("midrst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});
    check("midrst_rdata", data_from_mem, 32'h0);
    check("midrst_berr", {31'h0, bus_error}, 32'h0);
    check("midrst_adr", wb.adr_o, 32'h0);

    // read and write both asserted -> write
    run_txn(1'b1, 1'b1, 4'hF, 32'h0000_0400, 32'h0BAD_F00D, M_ACK, 2, 32'h9999_9999, 1'b0,
            3, 2, 32'h0, 1'b0);

    // write terminated by err -> zero data, error flagged
    run_txn(1'b0, 1'b1, 4'h8, 32'h0000_0500, 32'h0102_0304, M_ERR, 1, 32'h0, 1'b0,
            2, 1, 32'h0, 1'b1);

    // back-to-back fetch read then store write
    #1 rec = 1'b1;
    run_txn(1'b1, 1'b0, 4'hF, 32'h0000_1000, 32'h0, M_ACK, 1, 32'hA5A5_0001, 1'b0,
            2, 1, 32'hA5A5_0001, 1'b0);
    run_txn(1'b0, 1'b1, 4'hF, 32'h0000_2000, 32'h5A5A_0002, M_ACK, 1, 32'h0, 1'b0,
            2, 1, 32'h0, 1'b0);
    @(negedge clk);
    check("b2b_busy_pat", {26'h0, busy_pat}, {26'h0, 6'b110110});
    check("b2b_cyc_pat", {26'h0, cyc_pat}, {26'h0, 6'b010010});

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
